// File: rtl/hex_scan_driver_pkg.sv
// Shared constants and polarity helpers for the multiplexed hex display driver.
package hex_scan_driver_pkg;

  // Active-high GFEDCBA patterns for hex digits 0-F.
  localparam logic [6:0] SEG_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  // Pin level of a disabled digit.
  function automatic logic an_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/hex_scan_driver_hex_decode.sv
// Hex nibble to active-high 7-segment pattern; pin polarity is applied by the caller.
module hex_decode
  import hex_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_FONT[nibble];

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed hex display driver with double-buffered load, blanking,
// leading-zero suppression and PWM brightness.
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int DIV_W          = 11,
  parameter int BRIGHT_W       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lz_suppress,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic                  ready,
  output logic                  frame_done,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_cnt;
  logic                tick, wrap, accept, commit;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic                pend_vld;
  logic [4*DIGITS-1:0] pend_data, disp_data, src_data;
  logic [DIGITS-1:0]   pend_dp, pend_blank, disp_dp, disp_blank;
  logic [DIGITS-1:0]   src_dp, src_blank, lz_dark;
  logic                zero_run, dark;
  logic [3:0]          nib;
  logic [6:0]          font;
  logic [6:0]          seg_p0;
  logic                dp_p0;
  logic [DIGITS-1:0]   an_en_p0;
  logic [BRIGHT_W-1:0] pwm_b;
  logic                pwm_on;

  assign tick    = &div_cnt;
  assign wrap    = tick && (idx == LAST_IDX);
  assign idx_nxt = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign accept  = load && !pend_vld;
  assign commit  = wrap && pend_vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      if (tick) idx <= idx_nxt;
    end
  end

  // A load landing on the wrap tick sees pend_vld=0, so it waits a full frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld   <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      disp_data  <= '0;
      disp_dp    <= '0;
      disp_blank <= '0;
    end else begin
      if (accept) begin
        pend_vld   <= 1'b1;
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_blank <= blank_in;
      end else if (commit) begin
        pend_vld <= 1'b0;
      end
      if (commit) begin
        disp_data  <= pend_data;
        disp_dp    <= pend_dp;
        disp_blank <= pend_blank;
      end
    end
  end

  // Digit 0 of a committing frame is taken straight from the pending buffer.
  assign src_data  = commit ? pend_data  : disp_data;
  assign src_dp    = commit ? pend_dp    : disp_dp;
  assign src_blank = commit ? pend_blank : disp_blank;

  always_comb begin
    lz_dark  = '0;
    zero_run = lz_suppress;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (src_data[4*k +: 4] == 4'h0);
      lz_dark[k] = zero_run;
    end
  end

  assign nib  = src_data[4*int'(idx_nxt) +: 4];
  assign dark = src_blank[idx_nxt] || lz_dark[idx_nxt];

  hex_decode u_dec (
    .nibble (nib),
    .seg    (font)
  );

  // Output stage: registered in pin polarity, refreshed once per digit slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_p0   <= seg_off(SEG_ACTIVE_LOW);
      dp_p0    <= SEG_ACTIVE_LOW;
      an_en_p0 <= '0;
    end else if (tick) begin
      seg_p0   <= dark ? seg_off(SEG_ACTIVE_LOW) : (font ^ {7{SEG_ACTIVE_LOW}});
      dp_p0    <= (!dark && src_dp[idx_nxt]) ^ SEG_ACTIVE_LOW;
      an_en_p0 <= dark ? '0 : (DIGITS'(1) << idx_nxt);
    end
  end

  assign pwm_b  = div_cnt[DIV_W-1 -: BRIGHT_W];
  assign pwm_on = (brightness == '1) || (pwm_b < brightness);

  assign an         = (an_en_p0 & {DIGITS{pwm_on}}) ^ {DIGITS{an_off(AN_ACTIVE_LOW)}};
  assign seg        = seg_p0;
  assign dp         = dp_p0;
  assign ready      = !pend_vld;
  assign frame_done = wrap;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Directed bench for hex_scan_driver: a 4-digit and a 3-digit instance on one clock.
module tb_hex_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, load4, ready4, fd4, dpo4, lz;
  logic [15:0] data4;
  logic [3:0]  dp4, blank4, an4;
  logic [6:0]  seg4;
  logic [1:0]  brightness;

  logic        rst3, load3, ready3, fd3, dpo3;
  logic [11:0] data3;
  logic [2:0]  dp3, blank3, an3;
  logic [6:0]  seg3;

  int n_chk = 0;
  int n_err = 0;

  hex_scan_driver #(.DIGITS(4), .DIV_W(4), .BRIGHT_W(2)) dut4 (
    .clk (clk), .rst (rst4), .load (load4), .data_in (data4), .dp_in (dp4),
    .blank_in (blank4), .lz_suppress (lz), .brightness (brightness),
    .ready (ready4), .frame_done (fd4), .seg (seg4), .dp (dpo4), .an (an4)
  );

  hex_scan_driver #(.DIGITS(3), .DIV_W(4), .BRIGHT_W(2)) dut3 (
    .clk (clk), .rst (rst3), .load (load3), .data_in (data3), .dp_in (dp3),
    .blank_in (blank3), .lz_suppress (lz), .brightness (brightness),
    .ready (ready3), .frame_done (fd3), .seg (seg3), .dp (dpo3), .an (an3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stops in the cycle where frame_done is high; the next edge is the wrap.
  task automatic wait_fd(input bit sel3);
    int n;
    for (n = 0; n < 300; n++) begin
      tick_clk(1);
      if (sel3 ? fd3 : fd4) break;
    end
    if (n >= 300) check("fd_timeout", 0, 1);
  endtask

  task automatic do_load4(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] bl);
    load4 = 1'b1; data4 = d; dp4 = dpv; blank4 = bl;
    tick_clk(1);
    load4 = 1'b0;
  endtask

  logic [6:0] seg_1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
  logic [3:0] an_slot  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [6:0] seg_abcd [4] = '{7'h21, 7'h46, 7'h03, 7'h08};

  initial begin
    int act;
    int per;
    rst4 = 1'b0; rst3 = 1'b0; load4 = 1'b0; load3 = 1'b0; lz = 1'b0;
    data4 = '0; dp4 = '0; blank4 = '0; brightness = 2'd3;
    data3 = '0; dp3 = '0; blank3 = '0;

    tick_clk(3);
    check("rst_ready", ready4, 1);
    check("rst_fd", fd4, 0);
    check("rst_seg", seg4, 7'h7F);
    check("rst_dp", dpo4, 1);
    check("rst_an", an4, 4'hF);
    rst4 = 1'b1;

    // Basic load and one full frame of 1234.
    do_load4(16'h1234, 4'b0100, 4'b0000);
    check("ready_after_load", ready4, 0);
    wait_fd(1'b0);
    check("ready_before_wrap", ready4, 0);
    tick_clk(1);
    check("ready_after_wrap", ready4, 1);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("f1_an%0d", d), an4, an_slot[d]);
      check($sformatf("f1_seg%0d", d), seg4, seg_1234[d]);
      check($sformatf("f1_dp%0d", d), dpo4, (d == 2) ? 1'b0 : 1'b1);
      if (d < 2) tick_clk(16);
    end

    // Load in slot 2: rest of this frame keeps old data, extra load ignored.
    do_load4(16'hABCD, 4'b0000, 4'b0000);
    check("ready_mid", ready4, 0);
    tick_clk(15);
    check("old_an3", an4, 4'h7);
    check("old_seg3", seg4, 7'h79);
    do_load4(16'hFFFF, 4'b1111, 4'b0000);
    tick_clk(14);
    check("fd_pulse", fd4, 1);
    check("ready_blocked", ready4, 0);
    tick_clk(1);
    check("ready_commit", ready4, 1);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("f2_an%0d", d), an4, an_slot[d]);
      check($sformatf("f2_seg%0d", d), seg4, seg_abcd[d]);
      check($sformatf("f2_dp%0d", d), dpo4, 1);
      if (d < 3) tick_clk(16);
    end

    // Leading-zero suppression.
    lz = 1'b1;
    do_load4(16'h0005, 4'b0000, 4'b0000);
    wait_fd(1'b0);
    tick_clk(1);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("lz5_an%0d", d), an4, (d == 0) ? 4'hE : 4'hF);
      check($sformatf("lz5_seg%0d", d), seg4, (d == 0) ? 7'h12 : 7'h7F);
      if (d < 3) tick_clk(16);
    end
    do_load4(16'h0000, 4'b0000, 4'b0000);
    wait_fd(1'b0);
    tick_clk(1);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("lz0_an%0d", d), an4, (d == 0) ? 4'hE : 4'hF);
      check($sformatf("lz0_seg%0d", d), seg4, (d == 0) ? 7'h40 : 7'h7F);
      if (d < 3) tick_clk(16);
    end

    // Load coincident with the wrap tick is deferred one frame.
    wait_fd(1'b0);
    do_load4(16'h1234, 4'b0100, 4'b0000);
    check("wrapload_ready", ready4, 0);
    check("wrapload_seg_old", seg4, 7'h40);
    wait_fd(1'b0);
    tick_clk(1);
    check("wrapload_seg_new", seg4, 7'h19);
    check("wrapload_ready1", ready4, 1);
    lz = 1'b0;

    // PWM brightness.
    brightness = 2'd1;
    #1;
    act = 0;
    for (int i = 0; i < 16; i++) begin
      if (an4 != 4'hF) act++;
      tick_clk(1);
    end
    check("pwm_b1_cycles", act, 4);
    brightness = 2'd0;
    #1;
    act = 0;
    for (int i = 0; i < 16; i++) begin
      if (an4 != 4'hF) act++;
      tick_clk(1);
    end
    check("pwm_b0_cycles", act, 0);
    brightness = 2'd3;

    // Per-digit blanking.
    do_load4(16'h1234, 4'b0000, 4'b0010);
    wait_fd(1'b0);
    tick_clk(1);
    check("blank_an0", an4, 4'hE);
    tick_clk(16);
    check("blank_an1", an4, 4'hF);
    check("blank_seg1", seg4, 7'h7F);
    tick_clk(16);
    check("blank_an2", an4, 4'hB);
    check("blank_seg2", seg4, 7'h24);

    // Three-digit instance: odd wrap, frame period, reset with pending load.
    rst3 = 1'b1;
    load3 = 1'b1; data3 = 12'h123; dp3 = 3'b000; blank3 = 3'b000;
    tick_clk(1);
    load3 = 1'b0;
    check("d3_ready_load", ready3, 0);
    wait_fd(1'b1);
    tick_clk(1);
    check("d3_an0", an3, 3'b110);
    check("d3_seg0", seg3, 7'h30);
    tick_clk(16);
    check("d3_an1", an3, 3'b101);
    check("d3_seg1", seg3, 7'h24);
    tick_clk(16);
    check("d3_an2", an3, 3'b011);
    check("d3_seg2", seg3, 7'h79);
    tick_clk(15);
    check("d3_fd", fd3, 1);
    per = 0;
    for (int i = 0; i < 200; i++) begin
      tick_clk(1);
      per++;
      if (fd3) break;
    end
    check("d3_fd_period", per, 48);
    tick_clk(1);
    check("d3_wrap_an0", an3, 3'b110);
    tick_clk(20);
    load3 = 1'b1; data3 = 12'h456;
    tick_clk(1);
    load3 = 1'b0;
    check("d3_pending", ready3, 0);
    rst3 = 1'b0;
    #1;
    check("d3_rst_an", an3, 3'b111);
    check("d3_rst_seg", seg3, 7'h7F);
    check("d3_rst_dp", dpo3, 1);
    check("d3_rst_ready", ready3, 1);
    tick_clk(2);
    rst3 = 1'b1;
    tick_clk(1);
    check("d3_ready_release", ready3, 1);
    wait_fd(1'b1);
    tick_clk(1);
    check("d3_discard_seg", seg3, 7'h40);
    check("d3_discard_an", an3, 3'b110);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
Name: hex_scan_driver

Overview:
Parametrised successor to the team's 4-digit multiplexed hex display driver. Time-multiplexes DIGITS hex digits onto one 7-segment bus plus decimal point. Adds:
- tear-free double-buffered loading with a ready handshake
- per-digit blanking and leading-zero suppression
- PWM brightness
- configurable output polarity

Sits between CPU-side debug/status registers and board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..16, need not be a power of two)
DIV_W, 11, scan prescaler width; one digit slot = 2^DIV_W clk cycles
BRIGHT_W, 4, brightness control width
SEG_ACTIVE_LOW, 1, 1: seg/dp pins drive 0 to light
AN_ACTIVE_LOW, 1, 1: an pins drive 0 to enable digit

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
load  in  1  request to capture data_in/dp_in/blank_in; accepted only when ready=1
data_in  in  4*DIGITS  nibble k -> digit k (digit 0 = rightmost)
dp_in  in  DIGITS  decimal point per digit, 1 = lit
blank_in  in  DIGITS  1 = digit forced dark
lz_suppress  in  1  1 = blank leading zero digits (live, not buffered)
brightness  in  BRIGHT_W  duty control (live)
ready  out  1  1 = pending buffer free
frame_done  out  1  one-cycle pulse when scan wraps to digit 0
seg  out  7  segments GFEDCBA, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
an  out  DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW

Behaviour:
- Reset (rst=0, async) clears the following:
  - prescaler, scan index, pending and displayed buffers all cleared
  - ready=1, frame_done=0
  - seg, dp and an all driven inactive (unlit, disabled)
- Prescaler: free-running DIV_W-bit counter. tick = counter all-ones.
- Scan index: on tick, advances 0..DIGITS-1, then wraps to 0. Explicit compare, no reliance on power-of-two overflow.
- Handshake:
  - load=1 while ready=1 captures the inputs into the pending buffer and sets ready=0 on the next cycle.
  - load while ready=0 is ignored; no overwrite.
- Commit on the wrap tick (index DIGITS-1 -> 0) with pending valid:
  - pending copies into the displayed buffer.
  - ready returns to 1 the cycle after that tick.
  - Digit 0 of the new data appears in the same edge, so one frame never mixes old and new data.
- Load in the same cycle as a wrap tick (ready=1): captured, but committed at the following wrap, not the current one.
- Output registers (seg, dp, an) update only on tick, for the digit the index is moving to.
- Digit k is dark (an inactive, seg/dp inactive) if any of:
  - blank_in bit k is set in the displayed buffer
  - lz_suppress=1 and digits DIGITS-1..k all have nibble 0, with k != 0 (digit 0 is never suppressed)
- Decoding: nibble to segments via the standard hex font 0-F.
- Brightness: let b = top BRIGHT_W bits of the prescaler. The an output is gated combinationally after the register, so PWM runs within the slot.
  - an active only while b < brightness
  - brightness = all-ones forces full-on
  - brightness = 0 forces all digits off; seg/dp are still registered
- frame_done pulses for one cycle, coincident with the wrap tick, whether or not a commit occurs.
- Reset mid-frame or with a pending load: pending data is discarded and ready=1 after reset release.

Decomposition:
- Shared package holds:
  - SEG_FONT constant array (16 x 7, active-high GFEDCBA)
  - SEG_OFF / AN_OFF helper functions for polarity
- Natural sub-module: the team's existing hex_decode, one instance per digit or one muxed instance. Polarity inversion happens at the output stage, not inside the decoder.

Test Plan:
1. Bench params: DIGITS=4, DIV_W=4, BRIGHT_W=2.
   - Reset, then load data_in=16'h1234, dp_in=4'b0100, brightness=3 -> ready=0 until the first wrap tick.
   - Over the next frame: an cycles 1110, 1101, 1011, 0111; seg = 0x19, 0x30, 0x24, 0x79; dp low only on digit 2.
2. Load 16'hABCD mid-frame (index 2) -> remaining slots of that frame still show 1234; digit 0 shows 0x21 (d) at the wrap; ready=1 one cycle after the wrap.
3. Second load while ready=0 (data 16'hFFFF) -> ignored; the display never shows F.
4. lz_suppress=1 with data 16'h0005 -> digits 3..1 dark (an bit held 1), digit 0 shows 0x12.
   - Same test with data 16'h0000 -> only digit 0 lit, showing 0x40.
5. brightness=1 -> each an active for 4 of 16 cycles per slot.
   - brightness=0 -> an stays 1111.
   - blank_in=4'b0010 -> digit 1 always dark.
6. DIGITS=3 (odd) -> index wraps 2 -> 0, an never asserts a fourth bit, frame_done every 48 cycles.
   - Assert rst=0 mid-frame with a load pending -> outputs go inactive immediately; ready=1 after release.
